sad_row_feeder: RTL
===================

# sad_row_feeder

Row feeder that sits in front of the horizontal SAD stage. It accepts a serial 8-bit pixel stream and packs each block row into one 64-bit filter word and one 64-bit reference word. It then presents both words to the SAD stage together with a one-cycle `input_ready` strobe, a row index and a block-last flag. It obeys a downstream busy signal, so each row is presented exactly once and no row is lost or duplicated.

## Interface
Parameters:
- `ROWS`, default 8: rows per block. Must be ≥ 2. The row counter wraps at `ROWS`.

Ports:
- `clk`  in  1  — single clock. All logic is on the rising edge.
- `rst_n`  in  1  — synchronous, active-low reset.
- `pix_in`  in  8  — pixel byte.
- `pix_valid`  in  1  — `pix_in` is valid.
- `pix_ready`  out  1  — feeder can accept a byte. A byte transfers on any edge where `pix_valid && pix_ready`.
- `blk_start`  in  1  — qualified by a transfer. Marks the byte as byte 0 of row 0 of a new block.
- `sad_busy`  in  1  — SAD consumer cannot take a new row this cycle.
- `filter_pix`  out  64  — filter row. The k-th filter byte received is at bits [8k+7:8k].
- `ref_pix`  out  64  — reference row, with the same packing.
- `input_ready`  out  1  — one-cycle strobe: a new row is on `filter_pix`/`ref_pix`.
- `row_idx`  out  3  — row number (0..ROWS-1) of the presented row.
- `blk_last`  out  1  — the presented row is row ROWS-1.

## Operation
- Byte order within a row:
  - transfers 0..7 are filter pixels 0..7;
  - transfers 8..15 are reference pixels 0..7.
  - A 4-bit byte counter tracks the position.
- FSM states:
  - FILL: assembling a row. `pix_ready`=1.
    - On the 16th transfer, if `sad_busy`=0 in that cycle, the row loads into the output registers on that edge. The FSM stays in FILL.
    - Otherwise the FSM goes to PEND.
  - PEND: a complete row is waiting. `pix_ready`=0.
    - On the first edge with `sad_busy`=0, the row loads into the output registers and the FSM returns to FILL.
- Output registers:
  - `filter_pix`, `ref_pix`, `row_idx` and `blk_last` change only on a load.
  - Between loads they hold their value.
  - `input_ready`=1 only in the cycle after a load.
- Row counter:
  - Captured with the row when it completes, then incremented modulo `ROWS`.
  - `blk_last` = (captured index == ROWS-1).
- `blk_start` on a transfer:
  - Discards any partial row.
  - The byte becomes filter byte 0.
  - The assembly row counter is forced to 0.
  - A row already complete (PEND, or the second buffer) is unaffected. It is still presented with its captured index.
- `blk_start` on byte 0 when the row counter is already 0 is a no-op beyond normal behaviour.

## Timing
- Reset values (`rst_n`=0 at an edge):
  - `filter_pix`=0, `ref_pix`=0, `input_ready`=0, `row_idx`=0, `blk_last`=0.
  - Byte and row counters are 0. State is FILL. `pix_ready`=1 from the first cycle after reset.
- Reset has priority over everything. Reset mid-row or in PEND drops all buffered data; no strobe follows.
- Latency: 16th byte transferred at edge N with `sad_busy`=0 gives `input_ready`=1 in cycle N+1.
- With `sad_busy`=1: the strobe comes in the cycle after the first edge where `sad_busy`=0.
- `pix_ready` is a registered function of state. It does not depend combinationally on `pix_valid` or `sad_busy`.
- Maximum throughput: one row per 16 cycles. `input_ready` is never high in two consecutive cycles.

## Configuration
- `SAD_FEEDER_PINGPONG_EN` defined:
  - A second 128-bit assembly buffer is added.
  - While a row is pending, the next row assembles into the other buffer, and `pix_ready` stays 1.
  - `pix_ready`=0 only when one row is pending and the second buffer has also completed.
  - Rows are presented in arrival order.
- Not defined: single buffer. `pix_ready`=0 for the whole PEND duration.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles. Required: all outputs at their reset values; `pix_ready`=1 in the first cycle after release.
- Single row: stream bytes 0x00..0x0F with `blk_start` on the first byte and `sad_busy`=0.
  - One cycle after the last byte: `input_ready`=1 for exactly one cycle, with `filter_pix`=0x0706050403020100, `ref_pix`=0x0F0E0D0C0B0A0908, `row_idx`=0, `blk_last`=0.
- Backpressure: raise `sad_busy` for 5 cycles around the 16th byte.
  - Without the macro: `pix_ready`=0 until `sad_busy` falls; the strobe is one cycle later; the data is unchanged.
  - With the macro: `pix_ready` stays 1 and the second row is accepted.
- Full block: 8 rows back-to-back with `ROWS`=8. Required: 8 strobes; `row_idx` 0..7; `blk_last`=1 only on the 8th; the 9th row has `row_idx`=0.
- `blk_start` mid-row: send 5 bytes, then 16 bytes with `blk_start` on the first. Required: a single strobe, carrying the 16 new bytes, with `row_idx`=0.
- Reset in PEND: hold `sad_busy`=1 after a complete row, then pulse `rst_n`=0. Required: no strobe afterwards and outputs zero.

Source files
------------

// File: rtl/sad_row_feeder.sv
// sad_row_feeder: packs a serial 8-bit pixel stream into 64-bit filter and
// reference row words for the horizontal SAD stage, honouring sad_busy so
// every completed row is presented exactly once and in arrival order.
// Optional build macro: SAD_FEEDER_PINGPONG_EN adds a second assembly buffer
// so the next row can be collected while a finished row waits on sad_busy.
module sad_row_feeder #(
  parameter int ROWS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic        blk_start,
  input  logic        sad_busy,
  output logic [63:0] filter_pix,
  output logic [63:0] ref_pix,
  output logic        input_ready,
  output logic [2:0]  row_idx,
  output logic        blk_last
);

  localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);

  // FULL is only reachable when the second assembly buffer exists.
  typedef enum logic [1:0] {
    FILL = 2'd0,
    PEND = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t      state_q;

  logic [63:0] asm_filt_q, asm_filt_d;
  logic [63:0] asm_ref_q, asm_ref_d;
  logic [3:0]  byte_cnt_q, byte_cnt_d;
  logic [2:0]  row_cnt_q, row_cnt_d;
  logic        row_done;
  logic        xfer;
  logic        can_load;

  logic [63:0] pend_filt_q;
  logic [63:0] pend_ref_q;
  logic [2:0]  pend_idx_q;
`ifdef SAD_FEEDER_PINGPONG_EN
  logic [2:0]  full_idx_q;
`endif

  logic [63:0] filter_q;
  logic [63:0] ref_q;
  logic        input_ready_q;
  logic [2:0]  row_idx_q;
  logic        blk_last_q;
  logic        pix_ready_q;

  assign xfer = pix_valid && pix_ready_q;

`ifdef SAD_FEEDER_PINGPONG_EN
  // With two buffers a pending row and a fresh row can be ready back to back;
  // skipping the cycle right after a load keeps the strobe from doubling up.
  assign can_load = !sad_busy && !input_ready_q;
`else
  assign can_load = !sad_busy;
`endif

  assign pix_ready   = pix_ready_q;
  assign filter_pix  = filter_q;
  assign ref_pix     = ref_q;
  assign input_ready = input_ready_q;
  assign row_idx     = row_idx_q;
  assign blk_last    = blk_last_q;

  // Assembly path: places the incoming byte, advances the byte/row counters
  // and flags the transfer that completes a row.
  always_comb begin
    asm_filt_d = asm_filt_q;
    asm_ref_d  = asm_ref_q;
    byte_cnt_d = byte_cnt_q;
    row_cnt_d  = row_cnt_q;
    row_done   = 1'b0;
    if (xfer) begin
      if (blk_start) begin
        asm_filt_d = {56'd0, pix_in};
        asm_ref_d  = 64'd0;
        byte_cnt_d = 4'd1;
        row_cnt_d  = 3'd0;
      end else begin
        if (!byte_cnt_q[3]) begin
          asm_filt_d[{byte_cnt_q[2:0], 3'b000} +: 8] = pix_in;
        end else begin
          asm_ref_d[{byte_cnt_q[2:0], 3'b000} +: 8] = pix_in;
        end
        byte_cnt_d = byte_cnt_q + 4'd1;
        if (byte_cnt_q == 4'd15) begin
          row_done  = 1'b1;
          row_cnt_d = (row_cnt_q == LAST_ROW) ? 3'd0 : row_cnt_q + 3'd1;
        end
      end
    end
  end

  // Control FSM plus all registered outputs: decides when a finished row is
  // handed to the SAD stage, parks it while sad_busy is high, and drives
  // pix_ready from the next state so it never depends on live inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= FILL;
      asm_filt_q    <= 64'd0;
      asm_ref_q     <= 64'd0;
      byte_cnt_q    <= 4'd0;
      row_cnt_q     <= 3'd0;
      pend_filt_q   <= 64'd0;
      pend_ref_q    <= 64'd0;
      pend_idx_q    <= 3'd0;
`ifdef SAD_FEEDER_PINGPONG_EN
      full_idx_q    <= 3'd0;
`endif
      filter_q      <= 64'd0;
      ref_q         <= 64'd0;
      input_ready_q <= 1'b0;
      row_idx_q     <= 3'd0;
      blk_last_q    <= 1'b0;
      pix_ready_q   <= 1'b1;
    end else begin
      asm_filt_q    <= asm_filt_d;
      asm_ref_q     <= asm_ref_d;
      byte_cnt_q    <= byte_cnt_d;
      row_cnt_q     <= row_cnt_d;
      input_ready_q <= 1'b0;
      case (state_q)
        FILL: begin
          if (row_done) begin
            if (can_load) begin
              filter_q      <= asm_filt_d;
              ref_q         <= asm_ref_d;
              row_idx_q     <= row_cnt_q;
              blk_last_q    <= (row_cnt_q == LAST_ROW);
              input_ready_q <= 1'b1;
            end else begin
              pend_filt_q <= asm_filt_d;
              pend_ref_q  <= asm_ref_d;
              pend_idx_q  <= row_cnt_q;
              state_q     <= PEND;
`ifdef SAD_FEEDER_PINGPONG_EN
              pix_ready_q <= 1'b1;
`else
              pix_ready_q <= 1'b0;
`endif
            end
          end
        end
        PEND: begin
`ifdef SAD_FEEDER_PINGPONG_EN
          if (can_load) begin
            filter_q      <= pend_filt_q;
            ref_q         <= pend_ref_q;
            row_idx_q     <= pend_idx_q;
            blk_last_q    <= (pend_idx_q == LAST_ROW);
            input_ready_q <= 1'b1;
            if (row_done) begin
              pend_filt_q <= asm_filt_d;
              pend_ref_q  <= asm_ref_d;
              pend_idx_q  <= row_cnt_q;
            end else begin
              state_q <= FILL;
            end
            pix_ready_q <= 1'b1;
          end else if (row_done) begin
            full_idx_q  <= row_cnt_q;
            state_q     <= FULL;
            pix_ready_q <= 1'b0;
          end
`else
          if (can_load) begin
            filter_q      <= pend_filt_q;
            ref_q         <= pend_ref_q;
            row_idx_q     <= pend_idx_q;
            blk_last_q    <= (pend_idx_q == LAST_ROW);
            input_ready_q <= 1'b1;
            state_q       <= FILL;
            pix_ready_q   <= 1'b1;
          end
`endif
        end
        FULL: begin
`ifdef SAD_FEEDER_PINGPONG_EN
          if (can_load) begin
            filter_q      <= pend_filt_q;
            ref_q         <= pend_ref_q;
            row_idx_q     <= pend_idx_q;
            blk_last_q    <= (pend_idx_q == LAST_ROW);
            input_ready_q <= 1'b1;
            pend_filt_q   <= asm_filt_q;
            pend_ref_q    <= asm_ref_q;
            pend_idx_q    <= full_idx_q;
            state_q       <= PEND;
            pix_ready_q   <= 1'b1;
          end
`else
          state_q     <= FILL;
          pix_ready_q <= 1'b1;
`endif
        end
        default: begin
          state_q     <= FILL;
          pix_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
